// File: rtl/firefly_swarm_ctrl.sv
// rtl/firefly_swarm_ctrl.sv - shares one queen flash edge across N sentry outputs in turn.
module firefly_swarm_ctrl #(
    parameter int N_SENTRY  = 4,
    parameter int PULSE_LEN = 15000,
    parameter int GAP_LEN   = 7500,
    parameter int CNT_W     = 14,
    parameter int IDX_W     = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                f0,
    input  logic                en,
    output logic [N_SENTRY-1:0] f_out,
    output logic                busy,
    output logic [IDX_W-1:0]    idx,
    output logic                done,
    output logic                overrun
);

    typedef enum logic [1:0] {IDLE, FLASH, GAP} state_t;

    localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_LEN - 1);
    // GAP is never entered when GAP_LEN is 0, so the terminal count there is a don't-care.
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'((GAP_LEN > 0) ? GAP_LEN - 1 : 0);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(N_SENTRY - 1);

    state_t                state, state_nx;
    logic [CNT_W-1:0]      cnt, cnt_nx;
    logic [IDX_W-1:0]      idx_nx;
    logic [N_SENTRY-1:0]   f_out_nx;
    logic                  busy_nx, done_nx, overrun_nx;
    logic                  sync1, sync2, hist;
    logic                  rise;

    assign rise = sync2 & ~hist;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            hist  <= 1'b0;
        end else begin
            sync1 <= f0;
            sync2 <= sync1;
            hist  <= sync2;
        end
    end

    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        idx_nx     = idx;
        done_nx    = 1'b0;
        overrun_nx = rise & (state != IDLE);
        case (state)
            IDLE: begin
                if (rise && en) begin
                    state_nx = FLASH;
                    cnt_nx   = '0;
                    idx_nx   = '0;
                end
            end
            FLASH: begin
                if (!en) begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                    idx_nx   = '0;
                end else if (cnt == PULSE_LAST) begin
                    cnt_nx = '0;
                    if (idx == IDX_LAST) begin
                        state_nx = IDLE;
                        idx_nx   = '0;
                        done_nx  = 1'b1;
                    end else if (GAP_LEN == 0) begin
                        idx_nx = idx + 1'b1;
                    end else begin
                        state_nx = GAP;
                    end
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            GAP: begin
                if (!en) begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                    idx_nx   = '0;
                end else if (cnt == GAP_LAST) begin
                    state_nx = FLASH;
                    cnt_nx   = '0;
                    idx_nx   = idx + 1'b1;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            default: begin
                state_nx = IDLE;
                cnt_nx   = '0;
                idx_nx   = '0;
            end
        endcase
        // Outputs are decoded from the next state so they can be registered without lag.
        f_out_nx = '0;
        if (state_nx == FLASH) begin
            f_out_nx = N_SENTRY'(1) << idx_nx;
        end
        busy_nx = (state_nx != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            idx     <= '0;
            f_out   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            overrun <= 1'b0;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            idx     <= idx_nx;
            f_out   <= f_out_nx;
            busy    <= busy_nx;
            done    <= done_nx;
            overrun <= overrun_nx;
        end
    end

endmodule

// File: tb/tb_firefly_swarm_ctrl.sv
// tb/tb_firefly_swarm_ctrl.sv - scoreboard bench for firefly_swarm_ctrl, gapped and zero-gap builds.
module tb_firefly_swarm_ctrl;

    typedef struct packed {
        logic [2:0] f;
        logic       busy;
        logic [1:0] idx;
        logic       done;
        logic       ovr;
    } obs_t;

    logic       clk;
    logic       rst_n;
    logic       f0;
    logic       en;
    logic [2:0] f_out1, f_out2;
    logic       busy1, busy2, done1, done2, ovr1, ovr2;
    logic [1:0] idx1, idx2;
    obs_t       obs1, obs2, exp_o;
    obs_t       q[$];
    int         checks;
    int         passed;

    firefly_swarm_ctrl #(.N_SENTRY(3), .PULSE_LEN(5), .GAP_LEN(3), .CNT_W(14), .IDX_W(2)) dut (
        .clk(clk), .rst_n(rst_n), .f0(f0), .en(en), .f_out(f_out1), .busy(busy1),
        .idx(idx1), .done(done1), .overrun(ovr1));

    firefly_swarm_ctrl #(.N_SENTRY(3), .PULSE_LEN(5), .GAP_LEN(0), .CNT_W(14), .IDX_W(2)) dut_nogap (
        .clk(clk), .rst_n(rst_n), .f0(f0), .en(en), .f_out(f_out2), .busy(busy2),
        .idx(idx2), .done(done2), .overrun(ovr2));

    assign obs1 = {f_out1, busy1, idx1, done1, ovr1};
    assign obs2 = {f_out2, busy2, idx2, done2, ovr2};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic void push_idle(input int n);
        for (int i = 0; i < n; i++) q.push_back(obs_t'(8'h00));
    endfunction

    // Reference trace of one full round, ending with the done cycle.
    function automatic void push_round(input int gap);
        obs_t e;
        for (int s = 0; s < 3; s++) begin
            for (int p = 0; p < 5; p++) begin
                e = '0; e.f = 3'(1 << s); e.busy = 1'b1; e.idx = 2'(s);
                q.push_back(e);
            end
            if (s < 2) begin
                for (int g = 0; g < gap; g++) begin
                    e = '0; e.busy = 1'b1; e.idx = 2'(s);
                    q.push_back(e);
                end
            end
        end
        e = '0; e.done = 1'b1;
        q.push_back(e);
    endfunction

    function automatic void mark_ovr(input int k);
        obs_t e;
        e = q[k]; e.ovr = 1'b1; q[k] = e;
    endfunction

    task automatic prep(input logic en_v);
        f0 = 1'b0;
        en = en_v;
        repeat (4) @(negedge clk);
        q.delete();
    endtask

    task automatic test_reset;
        rst_n = 1'b0; f0 = 1'b0; en = 1'b0;
        #12;
        checks++;
        if (obs1 !== obs_t'(8'h00)) $display("FAIL reset_hold dut got=%b want=%b", obs1, 8'h00);
        else passed++;
        checks++;
        if (obs2 !== obs_t'(8'h00)) $display("FAIL reset_hold nogap got=%b want=%b", obs2, 8'h00);
        else passed++;
        @(negedge clk); rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (obs1 !== obs_t'(8'h00)) $display("FAIL reset_release got=%b want=%b", obs1, 8'h00);
        else passed++;
    endtask

    task automatic test_single_round;
        int n;
        prep(1'b1);
        push_idle(2); push_round(3); push_idle(3);
        n = q.size();
        f0 = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            exp_o = q.pop_front();
            checks++;
            if (obs1 !== exp_o)
                $display("FAIL single_round cyc=%0d got f=%b busy=%b idx=%0d done=%b ovr=%b want f=%b busy=%b idx=%0d done=%b ovr=%b",
                         i, obs1.f, obs1.busy, obs1.idx, obs1.done, obs1.ovr,
                         exp_o.f, exp_o.busy, exp_o.idx, exp_o.done, exp_o.ovr);
            else passed++;
            if (i == 19) f0 = 1'b0;
        end
    endtask

    task automatic test_overrun;
        int n;
        prep(1'b1);
        push_idle(2); push_round(3); push_idle(4); push_round(3); push_idle(2);
        mark_ovr(10);
        mark_ovr(23);
        n = q.size();
        f0 = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            exp_o = q.pop_front();
            checks++;
            if (obs1 !== exp_o)
                $display("FAIL overrun cyc=%0d got f=%b busy=%b idx=%0d done=%b ovr=%b want f=%b busy=%b idx=%0d done=%b ovr=%b",
                         i, obs1.f, obs1.busy, obs1.idx, obs1.done, obs1.ovr,
                         exp_o.f, exp_o.busy, exp_o.idx, exp_o.done, exp_o.ovr);
            else passed++;
            case (i)
                3, 12, 23, 30: f0 = 1'b0;
                7, 20, 25:     f0 = 1'b1;
                default: ;
            endcase
        end
    endtask

    task automatic test_abort;
        int n;
        prep(1'b1);
        push_idle(2); push_round(3);
        while (q.size() > 8) void'(q.pop_back());
        push_idle(7); push_round(3); push_idle(2);
        n = q.size();
        f0 = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            exp_o = q.pop_front();
            checks++;
            if (obs1 !== exp_o)
                $display("FAIL abort cyc=%0d got f=%b busy=%b idx=%0d done=%b ovr=%b want f=%b busy=%b idx=%0d done=%b ovr=%b",
                         i, obs1.f, obs1.busy, obs1.idx, obs1.done, obs1.ovr,
                         exp_o.f, exp_o.busy, exp_o.idx, exp_o.done, exp_o.ovr);
            else passed++;
            case (i)
                4:  f0 = 1'b0;
                7:  en = 1'b0;
                10: en = 1'b1;
                12: f0 = 1'b1;
                30: f0 = 1'b0;
                default: ;
            endcase
        end
    endtask

    task automatic test_enable_gating;
        int n;
        prep(1'b0);
        push_idle(16); push_round(3); push_idle(2);
        n = q.size();
        f0 = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            exp_o = q.pop_front();
            checks++;
            if (obs1 !== exp_o)
                $display("FAIL enable_gating cyc=%0d got f=%b busy=%b idx=%0d done=%b ovr=%b want f=%b busy=%b idx=%0d done=%b ovr=%b",
                         i, obs1.f, obs1.busy, obs1.idx, obs1.done, obs1.ovr,
                         exp_o.f, exp_o.busy, exp_o.idx, exp_o.done, exp_o.ovr);
            else passed++;
            case (i)
                5:  en = 1'b1;
                10: f0 = 1'b0;
                13: f0 = 1'b1;
                default: ;
            endcase
        end
        f0 = 1'b0;
    endtask

    task automatic test_async_reset;
        int n;
        prep(1'b1);
        push_idle(2); push_round(3);
        while (q.size() > 11) void'(q.pop_back());
        n = q.size();
        f0 = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            exp_o = q.pop_front();
            checks++;
            if (obs1 !== exp_o)
                $display("FAIL pre_reset cyc=%0d got f=%b busy=%b idx=%0d want f=%b busy=%b idx=%0d",
                         i, obs1.f, obs1.busy, obs1.idx, exp_o.f, exp_o.busy, exp_o.idx);
            else passed++;
            if (i == 3) f0 = 1'b0;
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (obs1 !== obs_t'(8'h00)) $display("FAIL async_reset dut got=%b want=%b", obs1, 8'h00);
        else passed++;
        checks++;
        if (obs2 !== obs_t'(8'h00)) $display("FAIL async_reset nogap got=%b want=%b", obs2, 8'h00);
        else passed++;
        #1 rst_n = 1'b1;
        q.delete();
        push_idle(5);
        n = q.size();
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            exp_o = q.pop_front();
            checks++;
            if (obs1 !== exp_o) $display("FAIL post_reset cyc=%0d got=%b want=%b", i, obs1, exp_o);
            else passed++;
        end
    endtask

    task automatic test_zero_gap;
        int n;
        prep(1'b1);
        push_idle(2); push_round(0); push_idle(2);
        n = q.size();
        f0 = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            exp_o = q.pop_front();
            checks++;
            if (obs2 !== exp_o)
                $display("FAIL zero_gap cyc=%0d got f=%b busy=%b idx=%0d done=%b ovr=%b want f=%b busy=%b idx=%0d done=%b ovr=%b",
                         i, obs2.f, obs2.busy, obs2.idx, obs2.done, obs2.ovr,
                         exp_o.f, exp_o.busy, exp_o.idx, exp_o.done, exp_o.ovr);
            else passed++;
            if (i == 10) f0 = 1'b0;
        end
    endtask

    initial begin
        checks = 0;
        passed = 0;
        test_reset();
        test_single_round();
        test_overrun();
        test_abort();
        test_enable_gating();
        test_async_reset();
        test_zero_gap();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
